plot_sink: RTL and testbench

Pixel-plot receiver for the VGA drawing pipeline. Consumes the `vga_x`/`vga_y`/`vga_plot` strobe stream emitted by the shape drawers (circle, line, fill engines) and buffers it in a small FIFO. Converts each accepted pixel to a linear framebuffer address and writes it through an arbitrated memory write port. Also provides a full-screen clear sweep, so drawers never touch framebuffer memory directly.

---
 rtl/plot_sink.sv | 164 ++++++++++++++++
 tb/tb_plot_sink.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/plot_sink.sv
// rtl/plot_sink.sv - pixel-plot FIFO sink with linear addressing, framebuffer clear sweep and optional stats (PLOT_SINK_STATS_EN)
module plot_sink #(
    parameter int FIFO_DEPTH = 8,
    parameter int COLOUR_W   = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [7:0]          plot_x,
    input  logic [6:0]          plot_y,
    input  logic [COLOUR_W-1:0] plot_colour,
    input  logic                plot,
    output logic                plot_ready,
    input  logic                clear_start,
    input  logic [COLOUR_W-1:0] clear_colour,
    output logic                clear_busy,
    output logic                clear_done,
    output logic                mem_wr,
    output logic [14:0]         mem_addr,
    output logic [COLOUR_W-1:0] mem_wdata,
    input  logic                mem_grant,
    output logic                overflow,
    output logic [15:0]         pix_count,
    output logic [15:0]         drop_count
);
    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int EW = 15 + COLOUR_W;
    localparam logic [AW:0] DEPTH_C   = (AW+1)'(FIFO_DEPTH);
    localparam logic [14:0] LAST_ADDR = 15'd19199;

    typedef enum logic [1:0] {IDLE, DRAIN, CLEAR} state_t;

    state_t              state, state_nxt;
    logic [EW-1:0]       fifo_mem [FIFO_DEPTH];
    logic [AW-1:0]       wr_ptr, rd_ptr;
    logic [AW:0]         count, count_nxt;
    logic [14:0]         clear_addr;
    logic [COLOUR_W-1:0] clear_col;
    logic [14:0]         pix_addr;
    logic                in_bounds, full, empty, push, pop;
    logic                clear_accept, clear_last, ovf_drop;

    // y*160 + x as two shifts and an add; fits in 15 bits for in-bounds pixels
    assign pix_addr     = {1'b0, plot_y, 7'b0} + {3'b0, plot_y, 5'b0} + {7'b0, plot_x};
    assign in_bounds    = (plot_x < 8'd160) && (plot_y < 7'd120);
    assign full         = (count == DEPTH_C);
    assign empty        = (count == '0);
    assign plot_ready   = !full && !clear_busy;
    assign push         = plot && in_bounds && plot_ready;
    assign pop          = (state != CLEAR) && !empty && mem_grant;
    assign clear_accept = clear_start && !clear_busy;
    assign clear_last   = (state == CLEAR) && mem_grant && (clear_addr == LAST_ADDR);
    assign ovf_drop     = plot && in_bounds && full && !clear_busy;

    // occupancy after this cycle's push/pop; a simultaneous push and pop cancel
    always_comb begin
        count_nxt = count;
        case ({push, pop})
            2'b10:   count_nxt = count + 1'b1;
            2'b01:   count_nxt = count - 1'b1;
            default: count_nxt = count;
        endcase
    end

    // next state: a pending clear waits until the FIFO has fully drained
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DRAIN: begin
                if (clear_busy && count_nxt == '0)
                    state_nxt = CLEAR;
                else if (count_nxt != '0)
                    state_nxt = DRAIN;
                else
                    state_nxt = IDLE;
            end
            CLEAR:   if (clear_last) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // write port: sweep address while clearing, otherwise the FIFO head
    always_comb begin
        mem_wr    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (state == CLEAR) begin
            mem_wr    = 1'b1;
            mem_addr  = clear_addr;
            mem_wdata = clear_col;
        end else if (!empty) begin
            mem_wr    = 1'b1;
            mem_addr  = fifo_mem[rd_ptr][EW-1:COLOUR_W];
            mem_wdata = fifo_mem[rd_ptr][COLOUR_W-1:0];
        end
    end

    // FIFO payload storage; validity is tracked by count, so no reset needed
    always_ff @(posedge clk) begin
        if (push)
            fifo_mem[wr_ptr] <= {pix_addr, plot_colour};
    end

    // control state, pointers, clear sweep and sticky overflow
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            clear_busy <= 1'b0;
            clear_done <= 1'b0;
            clear_addr <= '0;
            clear_col  <= '0;
            overflow   <= 1'b0;
        end else begin
            state      <= state_nxt;
            count      <= count_nxt;
            clear_done <= clear_last;
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (clear_accept) begin
                clear_busy <= 1'b1;
                clear_col  <= clear_colour;
            end else if (clear_last) begin
                clear_busy <= 1'b0;
            end
            if (clear_last)
                clear_addr <= '0;
            else if (state == CLEAR && mem_grant)
                clear_addr <= clear_addr + 1'b1;
            if (clear_accept)
                overflow <= 1'b0;
            else if (ovf_drop)
                overflow <= 1'b1;
        end
    end

`ifdef PLOT_SINK_STATS_EN
    logic [15:0] pix_q, drop_q;
    logic        drop_evt;

    assign drop_evt = plot && (!in_bounds || (full && !clear_busy));

    // saturating statistics, zeroed by each accepted clear
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pix_q  <= '0;
            drop_q <= '0;
        end else if (clear_accept) begin
            pix_q  <= '0;
            drop_q <= '0;
        end else begin
            if (pop && pix_q != 16'hFFFF)       pix_q  <= pix_q + 16'd1;
            if (drop_evt && drop_q != 16'hFFFF) drop_q <= drop_q + 16'd1;
        end
    end

    assign pix_count  = pix_q;
    assign drop_count = drop_q;
`else
    assign pix_count  = '0;
    assign drop_count = '0;
`endif
endmodule

// File: tb/tb_plot_sink.sv
// tb/tb_plot_sink.sv - scoreboard testbench for plot_sink
module tb_plot_sink;
    localparam int DEPTH = 8;
    localparam int CW    = 3;
`ifdef PLOT_SINK_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic [7:0]    plot_x;
    logic [6:0]    plot_y;
    logic [CW-1:0] plot_colour;
    logic          plot;
    logic          plot_ready;
    logic          clear_start;
    logic [CW-1:0] clear_colour;
    logic          clear_busy;
    logic          clear_done;
    logic          mem_wr;
    logic [14:0]   mem_addr;
    logic [CW-1:0] mem_wdata;
    logic          mem_grant;
    logic          overflow;
    logic [15:0]   pix_count;
    logic [15:0]   drop_count;

    plot_sink #(.FIFO_DEPTH(DEPTH), .COLOUR_W(CW)) dut (
        .clk(clk), .rst(rst), .plot_x(plot_x), .plot_y(plot_y),
        .plot_colour(plot_colour), .plot(plot), .plot_ready(plot_ready),
        .clear_start(clear_start), .clear_colour(clear_colour),
        .clear_busy(clear_busy), .clear_done(clear_done), .mem_wr(mem_wr),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_grant(mem_grant),
        .overflow(overflow), .pix_count(pix_count), .drop_count(drop_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit clr;
        int addr;
        int data;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   failures = 0;

    int   m_pending;
    bit   m_busy;
    bit   m_ovf;
    bit   m_done_exp;
    int   m_pix;
    int   m_drop;
    bit   prev_hold;
    int   prev_addr;
    int   prev_data;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
        end
    endtask

    function automatic int sat_inc(input int v);
        return (v >= 65535) ? 65535 : v + 1;
    endfunction

    // reference model + scoreboard monitor, evaluated mid-cycle
    always @(negedge clk) begin
        int   pending0;
        bit   last_clear;
        exp_t e;
        if (rst) begin
            exp_q.delete();
            m_pending  = 0;
            m_busy     = 0;
            m_ovf      = 0;
            m_done_exp = 0;
            m_pix      = 0;
            m_drop     = 0;
            prev_hold  = 0;
        end else begin
            pending0   = m_pending;
            last_clear = 0;
            check("plot_ready", plot_ready, (pending0 < DEPTH) && !m_busy);
            check("clear_busy", clear_busy, m_busy);
            check("clear_done", clear_done, m_done_exp);
            check("overflow", overflow, m_ovf);
            check("pix_count", pix_count, STATS ? m_pix : 0);
            check("drop_count", drop_count, STATS ? m_drop : 0);
            if (pending0 > 0)
                check("mem_wr_pending", mem_wr, 1);
            else if (!m_busy)
                check("mem_wr_idle", mem_wr, 0);
            if (prev_hold) begin
                check("hold_wr", mem_wr, 1);
                check("hold_addr", mem_addr, prev_addr);
                check("hold_data", mem_wdata, prev_data);
            end
            prev_hold = mem_wr && !mem_grant;
            prev_addr = mem_addr;
            prev_data = mem_wdata;

            if (mem_wr && mem_grant) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_write", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check(e.clr ? "clear_addr" : "plot_addr", mem_addr, e.addr);
                    check(e.clr ? "clear_data" : "plot_data", mem_wdata, e.data);
                    if (e.clr && e.addr == 19199) last_clear = 1;
                    if (!e.clr) begin
                        m_pending--;
                        m_pix = sat_inc(m_pix);
                    end
                end
            end
            m_done_exp = last_clear;

            if (plot) begin
                if (plot_x >= 160 || plot_y >= 120) begin
                    m_drop = sat_inc(m_drop);
                end else if (m_busy) begin
                    // blocked by a pending clear: silently dropped
                end else if (pending0 >= DEPTH) begin
                    m_ovf  = 1;
                    m_drop = sat_inc(m_drop);
                end else begin
                    exp_q.push_back('{clr: 1'b0, addr: int'(plot_y) * 160 + int'(plot_x),
                                      data: int'(plot_colour)});
                    m_pending++;
                end
            end
            if (clear_start && !m_busy) begin
                m_busy = 1;
                m_ovf  = 0;
                m_pix  = 0;
                m_drop = 0;
                for (int a = 0; a < 19200; a++)
                    exp_q.push_back('{clr: 1'b1, addr: a, data: int'(clear_colour)});
            end
            if (last_clear) m_busy = 0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_plot(input int x, input int y, input int c);
        plot        = 1'b1;
        plot_x      = 8'(x);
        plot_y      = 7'(y);
        plot_colour = CW'(c);
        tick();
        plot = 1'b0;
    endtask

    task automatic do_clear(input int c);
        clear_start  = 1'b1;
        clear_colour = CW'(c);
        tick();
        clear_start = 1'b0;
    endtask

    task automatic wait_clear(input bit rand_grant, input int limit);
        int n = 0;
        while (m_busy && n < limit) begin
            if (rand_grant) mem_grant = 1'($urandom_range(0, 1));
            tick();
            n++;
        end
        if (m_busy) check("clear_timeout", 1, 0);
        mem_grant = 1'b1;
        tick();
    endtask

    initial begin
        rst = 1'b1; plot = 1'b0; plot_x = '0; plot_y = '0; plot_colour = '0;
        clear_start = 1'b0; clear_colour = '0; mem_grant = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_plot_ready", plot_ready, 1);
        check("rst_mem_wr", mem_wr, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_clear_busy", clear_busy, 0);
        rst = 1'b0;
        tick();

        // single pixel, latency and address
        mem_grant = 1'b1;
        do_plot(10, 5, 3);
        @(negedge clk);
        check("lat_wr", mem_wr, 1);
        check("lat_addr", mem_addr, 810);
        check("lat_data", mem_wdata, 3);
        tick();
        @(negedge clk);
        check("pix_after_one", pix_count, STATS ? 1 : 0);
        tick();

        // out-of-bounds drops
        do_plot(160, 0, 1);
        do_plot(0, 120, 2);
        @(negedge clk);
        check("oob_drop_count", drop_count, STATS ? 2 : 0);
        check("oob_overflow", overflow, 0);
        tick();

        // fill FIFO with grant low, ninth pixel overflows
        mem_grant = 1'b0;
        for (int i = 0; i < 9; i++) do_plot(i * 3, 7, i % 8);
        @(negedge clk);
        check("full_ready", plot_ready, 0);
        check("full_overflow", overflow, 1);
        tick();
        mem_grant = 1'b1;
        repeat (DEPTH + 2) tick();

        // queued pixels drain ahead of a clear; plots during clear are blocked
        mem_grant = 1'b0;
        do_plot(1, 1, 1);
        do_plot(2, 2, 2);
        do_plot(159, 119, 7);
        do_clear(0);
        do_plot(4, 4, 4);
        do_plot(5, 5, 5);
        mem_grant = 1'b1;
        wait_clear(1'b0, 25000);
        @(negedge clk);
        check("clear_ovf_cleared", overflow, 0);
        tick();

        // clear under a randomly toggling grant
        do_clear(5);
        wait_clear(1'b1, 60000);

        // random traffic with random grant
        for (int i = 0; i < 400; i++) begin
            plot        = ($urandom_range(0, 3) != 0);
            plot_x      = 8'($urandom_range(0, 175));
            plot_y      = 7'($urandom_range(0, 127));
            plot_colour = CW'($urandom);
            mem_grant   = ($urandom_range(0, 2) != 0);
            tick();
        end
        plot = 1'b0;
        mem_grant = 1'b1;
        repeat (DEPTH + 4) tick();

        // asynchronous reset in the middle of a sweep
        do_clear(2);
        repeat (500) tick();
        #2;
        rst = 1'b1;
        #1;
        check("arst_mem_wr", mem_wr, 0);
        check("arst_mem_addr", mem_addr, 0);
        check("arst_mem_wdata", mem_wdata, 0);
        check("arst_clear_busy", clear_busy, 0);
        check("arst_clear_done", clear_done, 0);
        check("arst_plot_ready", plot_ready, 1);
        check("arst_overflow", overflow, 0);
        check("arst_pix", pix_count, 0);
        check("arst_drop", drop_count, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_ready", plot_ready, 1);
        tick();
        do_plot(159, 119, 6);
        repeat (3) tick();
        check("final_queue_empty", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
